// File: rtl/knn_query_ctrl.sv
// knn_query_ctrl: query sequencer for the k-NN core.
// Latches a query vector, holds the core in reset to clear its candidate
// lists, streams every training sample from a synchronous ROM, waits for
// the core pipeline to drain and captures the result with a done pulse.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; core released, ROM idle
// CLEAR   | core_rst_n held low for CLR_CYC cycles
// STREAM  | one ROM read per cycle, addresses 0..COM_NUM-1
// DRAIN   | DRAIN_CYC cycles for the last samples to leave the core pipe
// CAPTURE | result registered on entry; done pulses for this one cycle
module knn_query_ctrl #(
  parameter int WIDE      = 48,
  parameter int DATA_WIDE = 3,
  parameter int COM_NUM   = 600,
  parameter int ADDR_W    = 11,
  parameter int CLR_CYC   = 2,
  parameter int DRAIN_CYC = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [WIDE-1:0]           query_feature,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_WIDE-1:0]      result,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [WIDE+DATA_WIDE-1:0] rom_data,
  output logic                      core_rst_n,
  output logic [WIDE-1:0]           core_feature,
  output logic [WIDE+DATA_WIDE-1:0] core_train_data,
  input  logic [DATA_WIDE-1:0]      core_result
);

  localparam int CNT_W = 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COM_NUM - 1);
  localparam logic [CNT_W-1:0]  CLR_LOAD  = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0]  DRN_LOAD  = CNT_W'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    STREAM  = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [ADDR_W-1:0]           rom_addr_q, rom_addr_d;
  logic                        rom_en_q;
  logic                        rom_vld_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        core_rst_n_q;
  logic [DATA_WIDE-1:0]        result_q;
  logic [WIDE-1:0]             core_feature_q;
  logic                        accept;
  logic                        abort_hit;

  // A start is only honoured in IDLE, and an abort in the same cycle drops it.
  assign accept    = (state_q == IDLE) && start && !abort;
  assign abort_hit = (state_q != IDLE) && abort;

  // Next-state, down-counter and address sequencing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rom_addr_d = rom_addr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CLEAR;
          cnt_d   = CLR_LOAD;
        end
      end
      CLEAR: begin
        if (cnt_q == '0) begin
          state_d    = STREAM;
          rom_addr_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STREAM: begin
        if (rom_addr_q == LAST_ADDR) begin
          state_d = DRAIN;
          cnt_d   = DRN_LOAD;
        end else begin
          rom_addr_d = rom_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CAPTURE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Abort cancels from any active state; the address freezes with rom_en low.
    if (abort_hit) begin
      state_d    = IDLE;
      rom_addr_d = rom_addr_q;
    end
  end

  // State, counters and registered outputs, all decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rom_addr_q     <= '0;
      rom_en_q       <= 1'b0;
      rom_vld_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      core_rst_n_q   <= 1'b0;
      result_q       <= '0;
      core_feature_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rom_addr_q   <= rom_addr_d;
      rom_en_q     <= (state_d == STREAM);
      rom_vld_q    <= rom_en_q;
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == CAPTURE);
      core_rst_n_q <= !((state_d == CLEAR) || abort_hit);
      if (state_d == CAPTURE) begin
        result_q <= core_result;
      end
      if (accept) begin
        core_feature_q <= query_feature;
      end
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign result          = result_q;
  assign rom_en          = rom_en_q;
  assign rom_addr        = rom_addr_q;
  assign core_rst_n      = core_rst_n_q;
  assign core_feature    = core_feature_q;
  // ROM data is only meaningful the cycle after a read; otherwise feed zeros.
  assign core_train_data = rom_vld_q ? rom_data : '0;

endmodule

// File: tb/tb_knn_query_ctrl.sv
// Bench for knn_query_ctrl: a small-parameter instance driven with directed
// and random start/abort traffic against a timeline model, plus a
// default-parameter instance running one full query.
module tb_knn_query_ctrl;

  localparam int WIDE = 48;
  localparam int DW   = 3;
  localparam int COM  = 4;
  localparam int AW   = 3;
  localparam int CLR  = 2;
  localparam int DRN  = 3;
  localparam int L    = CLR + COM + DRN + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 start, abort;
  logic [WIDE-1:0]      query_feature;
  logic                 busy, done;
  logic [DW-1:0]        result;
  logic                 rom_en;
  logic [AW-1:0]        rom_addr;
  logic [WIDE+DW-1:0]   rom_data;
  logic                 core_rst_n;
  logic [WIDE-1:0]      core_feature;
  logic [WIDE+DW-1:0]   core_train_data;
  logic [DW-1:0]        core_result;

  knn_query_ctrl #(.WIDE(WIDE), .DATA_WIDE(DW), .COM_NUM(COM), .ADDR_W(AW),
                   .CLR_CYC(CLR), .DRAIN_CYC(DRN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .query_feature(query_feature), .busy(busy), .done(done), .result(result),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .core_rst_n(core_rst_n), .core_feature(core_feature),
    .core_train_data(core_train_data), .core_result(core_result));

  logic [WIDE+DW-1:0] mem [8];
  always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];

  // default-parameter instance
  logic                 rst_d_n, start_d, abort_d;
  logic [47:0]          qf_d;
  logic                 busy_d, done_d, rom_en_d, core_rst_n_d;
  logic [2:0]           result_d, core_result_d;
  logic [10:0]          rom_addr_d;
  logic [50:0]          rom_data_d, train_d;
  logic [47:0]          feat_d;

  knn_query_ctrl dut_def (
    .clk(clk), .rst_n(rst_d_n), .start(start_d), .abort(abort_d),
    .query_feature(qf_d), .busy(busy_d), .done(done_d), .result(result_d),
    .rom_en(rom_en_d), .rom_addr(rom_addr_d), .rom_data(rom_data_d),
    .core_rst_n(core_rst_n_d), .core_feature(feat_d),
    .core_train_data(train_d), .core_result(core_result_d));

  always @(posedge clk) if (rom_en_d) rom_data_d <= 51'(rom_addr_d);

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Timeline model: a query accepted in cycle t0 owns cycles t0+1..t0+L.
  int                 n = 0;
  int                 t0 = 0;
  bit                 active = 0;
  bit                 abort_rst = 0;
  bit                 prev_en = 0;
  int                 prev_addr = 0;
  int                 exp_addr = 0;
  logic [DW-1:0]      exp_result = '0;
  logic [WIDE-1:0]    exp_feat = '0;

  task automatic check_now(output bit cb, output int d, output bit ce);
    logic [WIDE+DW-1:0] exp_train;
    d  = n - t0;
    cb = active && d >= 1 && d <= L;
    ce = cb && d >= CLR + 1 && d <= CLR + COM;
    if (ce) exp_addr = d - CLR - 1;
    exp_train = prev_en ? mem[prev_addr] : '0;
    chk("busy", 64'(busy), 64'(cb));
    chk("done", 64'(done), 64'(cb && d == L));
    chk("rom_en", 64'(rom_en), 64'(ce));
    chk("rom_addr", 64'(rom_addr), 64'(exp_addr));
    chk("core_rst_n", 64'(core_rst_n), 64'(!((cb && d <= CLR) || abort_rst)));
    chk("train_data", 64'(core_train_data), 64'(exp_train));
    chk("result", 64'(result), 64'(exp_result));
    chk("core_feature", 64'(core_feature), 64'(exp_feat));
  endtask

  task automatic cyc(input bit st, input bit ab);
    bit cb, ce;
    int d;
    check_now(cb, d, ce);
    start         = st;
    abort         = ab;
    query_feature = 48'({$urandom, $urandom});
    core_result   = DW'($urandom);
    abort_rst     = cb && ab;
    if (cb && !ab && d == L - 1) exp_result = core_result;
    if (cb && ab) active = 0;
    else if (!cb && st && !ab) begin
      active   = 1;
      t0       = n;
      exp_feat = query_feature;
    end
    prev_en   = ce;
    prev_addr = exp_addr;
    @(negedge clk);
    n++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0);
  endtask

  task automatic do_reset();
    start = 0;
    abort = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_rom_en", 64'(rom_en), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("rst_feature", 64'(core_feature), 64'd0);
    chk("rst_train", 64'(core_train_data), 64'd0);
    active = 0; abort_rst = 0; prev_en = 0; exp_addr = 0;
    exp_result = '0; exp_feat = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n += 2;
  endtask

  bit def_fin = 0;

  initial begin
    int done_at, ndone, maxaddr;
    rst_d_n = 0; start_d = 0; abort_d = 0; qf_d = 48'h1234_5678_9abc; core_result_d = 3'd6;
    done_at = -1; ndone = 0; maxaddr = 0;
    repeat (2) @(negedge clk);
    rst_d_n = 1;
    @(negedge clk);
    start_d = 1;
    @(negedge clk);
    start_d = 0;
    for (int k = 1; k <= 800; k++) begin
      if (done_d) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      if (rom_en_d && int'(rom_addr_d) > maxaddr) maxaddr = int'(rom_addr_d);
      @(negedge clk);
    end
    chk("def_done_cycle", 64'(done_at), 64'd611);
    chk("def_done_count", 64'(ndone), 64'd1);
    chk("def_max_addr", 64'(maxaddr), 64'd599);
    chk("def_result", 64'(result_d), 64'd6);
    chk("def_busy_after", 64'(busy_d), 64'd0);
    def_fin = 1;
  end

  initial begin
    int waited;
    for (int i = 0; i < 8; i++) mem[i] = 51'({$urandom, $urandom});
    start = 0; abort = 0; query_feature = '0; core_result = '0;
    rst_n = 1'b1;
    @(negedge clk);
    do_reset();
    idle(3);
    // single query
    cyc(1, 0); idle(12);
    // start while busy is ignored; start at T+11 accepted
    cyc(1, 0); idle(4); cyc(1, 0); idle(5); cyc(1, 0); idle(12);
    // abort at T+5, then abort+start together in IDLE
    cyc(1, 0); idle(4); cyc(0, 1); idle(4);
    cyc(1, 1); idle(3);
    // start held through the done cycle
    cyc(1, 0); idle(8); cyc(1, 0); cyc(1, 0); idle(12);
    // async reset mid-query, then a full query
    cyc(1, 0); idle(3); do_reset(); cyc(1, 0); idle(12);
    // random traffic
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0);
    idle(12);
    waited = 0;
    while (!def_fin && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!def_fin) chk("def_timeout", 64'd0, 64'd1);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/knn_query_ctrl.md
# knn_query_ctrl

Query sequencer for the k-NN core. It accepts one query feature vector per start pulse and holds the core in reset to clear its candidate lists. It then streams all COM_NUM training samples from a synchronous sample ROM into the core, waits for the core pipeline to drain, and captures the class or regression result with a one-cycle done pulse. It sits between the host/query interface and the k-NN core plus its training-sample memory.

## Interface
Parameters:
- WIDE, 48: query feature vector width (FEATURE_NUM×LEN).
- DATA_WIDE, 3: label/result width.
- COM_NUM, 600: number of training samples per query, 1..2048.
- ADDR_W, 11: ROM address width; 2^ADDR_W ≥ COM_NUM.
- CLR_CYC, 2: cycles core_rst_n is held low before streaming, 1..15.
- DRAIN_CYC, 8: cycles waited after the last ROM read before capture, 1..255.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  query request; sampled only in IDLE.
- abort  in  1  synchronous cancel of the query in flight.
- query_feature  in  WIDE  query vector; latched on the accepted start.
- busy  out  1  query in progress.
- done  out  1  one-cycle pulse; result is valid from this cycle onward.
- result  out  DATA_WIDE  captured core result, held until the next done.
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDR_W  ROM address.
- rom_data  in  WIDE+DATA_WIDE  ROM read data, valid 1 cycle after rom_en.
- core_rst_n  out  1  registered active-low reset to the core.
- core_feature  out  WIDE  latched query vector to the core.
- core_train_data  out  WIDE+DATA_WIDE  sample to the core.
- core_result  in  DATA_WIDE  core result.

## Operation
- FSM states: IDLE → CLEAR → STREAM → DRAIN → CAPTURE → IDLE.
- IDLE: start=1 latches query_feature into core_feature, loads the CLEAR counter, and moves to CLEAR. start=0 stays in IDLE.
- CLEAR: core_rst_n=0 for CLR_CYC cycles, then STREAM.
- STREAM: rom_en=1, rom_addr=0,1,…,COM_NUM−1, one address per cycle. After address COM_NUM−1 the state moves to DRAIN.
- core_train_data = rom_data in every cycle following a cycle with rom_en=1; otherwise it is all zeros. The core's internal sample count ignores the trailing zero samples.
- DRAIN: counts DRAIN_CYC cycles, then CAPTURE.
- CAPTURE: result ← core_result, done=1, busy=1. Next state is IDLE.
- core_rst_n is 1 in all states except CLEAR, reset, and the abort cycle.
- start while busy is ignored and not queued. A start in the same cycle as done's IDLE return is accepted on the following cycle only if start is still high.
- abort=1 in any non-IDLE state:
  - next state is IDLE; rom_en=0; core_rst_n=0 for one cycle.
  - no done pulse; result unchanged.
  - abort in IDLE has no effect. abort and start together in IDLE: abort wins and the start is dropped.
- rom_addr holds its last value when rom_en=0 and returns to 0 on entry to STREAM.
- Counters are compared for equality only; no wrap-around occurs within legal parameter ranges.

## Timing
- Reset values: busy=0, done=0, result=0, rom_en=0, rom_addr=0, core_rst_n=0 (released to 1 on the first clock after rst_n deasserts), core_feature=0, core_train_data=0, state IDLE.
- Cycle labels, with start sampled at edge T:
  - CLEAR: T+1..T+CLR_CYC.
  - STREAM: T+CLR_CYC+1..T+CLR_CYC+COM_NUM.
  - Samples valid at the core: T+CLR_CYC+2..T+CLR_CYC+COM_NUM+1.
  - DRAIN: the following DRAIN_CYC cycles.
  - done: cycle T+CLR_CYC+COM_NUM+DRAIN_CYC+1.
- Defaults: done at T+611.
- busy is 1 from T+1 through the done cycle inclusive.
- Minimum spacing between accepted starts: CLR_CYC+COM_NUM+DRAIN_CYC+2 cycles.
- All outputs are registered except core_train_data, which is a gated path from rom_data.
- Asynchronous reset mid-query returns to the reset values immediately, with no done pulse.

## Test plan
- COM_NUM=4, CLR_CYC=2, DRAIN_CYC=3; start at T:
  - core_rst_n low during T+1..T+2.
  - rom_addr 0,1,2,3 with rom_en=1 during T+3..T+6.
  - core_train_data matches ROM contents during T+4..T+7.
  - done single pulse at T+10; busy high T+1..T+10.
- Same setup with core_result=5 during CAPTURE and 2 afterwards: result=5 after done and stays 5.
- start pulsed again at T+5 (busy): ignored, no second CLEAR. A new start at T+11: done at T+21.
- abort at T+5:
  - IDLE at T+6; core_rst_n=0 for one cycle.
  - No done pulse; result keeps its previous value.
- rst_n asserted at T+4:
  - all outputs at reset values immediately.
  - after release, a start runs a full query from address 0 with done at the expected cycle.
- Defaults: a single query yields done exactly 611 cycles after start; rom_addr reaches 599 and never 600.
